// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the signals between the instruction-fetch requester, the data-stage
// requester, the shared single-port RAM and the arbiter.
//   IF side : if_req, if_addr, if_flush -> arbiter; if_rdata, if_done, IF_VALID <- arbiter
//   MEM side: mem_req, mem_we, mem_be, mem_addr, mem_wdata -> arbiter;
//             mem_rdata, mem_done, MEM_VALID <- arbiter
//   RAM side: ram_en, ram_we, ram_addr, ram_wdata <- arbiter; ram_rdata -> arbiter
//   busy    : arbiter has a transaction in flight
// modport slave is the arbiter's view, master is the environment's view.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [31:0]       if_rdata;
    logic              if_done;
    logic              IF_VALID;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_done;
    logic              MEM_VALID;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_rdata, if_done, IF_VALID,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_done, MEM_VALID,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_rdata, if_done, IF_VALID,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_done, MEM_VALID,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port RAM between an instruction-fetch requester and a
// data-stage requester. One transaction in flight at a time; contention is
// resolved round-robin, MEM winning the first contention after reset.
// Read data is valid LATENCY cycles after the ram_en cycle; the requester
// sees a one-cycle done pulse the cycle after capture.
// Ports:
//   clk   : clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requesters, RAM port, busy)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.slave    bus
);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q;
    logic              kill_q;
    logic              last_if_q;   // 1: IF was granted last (reset value lets MEM win)
    logic              mem_we_q;
    logic              ram_en_q;
    logic [3:0]        ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [31:0]       ram_wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       mem_rdata_q;
    logic              if_done_q;
    logic              mem_done_q;

    logic              if_elig, mem_elig;
    logic              grant_if, grant_mem, grant;
    logic              capture;
    logic              if_deliver;

    // A requester whose done is showing this cycle is still holding the
    // request it just completed, so it must not be issued again.
    always_comb begin
        if_elig   = bus.if_req & ~bus.if_flush & ~if_done_q;
        mem_elig  = bus.mem_req & ~mem_done_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        capture   = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (if_elig && (!mem_elig || !last_if_q)) begin
                    grant_if = 1'b1;
                    state_d  = IF_BUSY;
                end else if (mem_elig) begin
                    grant_mem = 1'b1;
                    state_d   = MEM_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (cnt_q == LAT_C) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = grant_if | grant_mem;
    // A flush in the capture cycle itself also kills the fetch.
    assign if_deliver = capture && (state_q == IF_BUSY) && !kill_q && !bus.if_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 4'd0;
            kill_q      <= 1'b0;
            last_if_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'h0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            // RAM command is a single-cycle strobe issued on the grant edge.
            ram_en_q    <= grant;
            ram_we_q    <= (grant_mem && bus.mem_we) ? bus.mem_be : 4'h0;
            ram_wdata_q <= grant ? bus.mem_wdata : 32'h0;
            if (grant_if) begin
                ram_addr_q <= bus.if_addr;
            end else if (grant_mem) begin
                ram_addr_q <= bus.mem_addr;
            end

            if (grant) begin
                cnt_q     <= 4'd0;
                kill_q    <= 1'b0;
                last_if_q <= grant_if;
                mem_we_q  <= grant_mem & bus.mem_we;
            end else if (capture) begin
                cnt_q  <= 4'd0;
                kill_q <= 1'b0;
            end else if (state_q != IDLE) begin
                cnt_q <= cnt_q + 4'd1;
                if (state_q == IF_BUSY && bus.if_flush) begin
                    kill_q <= 1'b1;
                end
            end

            if_done_q  <= if_deliver;
            mem_done_q <= capture && (state_q == MEM_BUSY);
            if (if_deliver) begin
                if_rdata_q <= bus.ram_rdata;
            end
            if (capture && (state_q == MEM_BUSY) && !mem_we_q) begin
                mem_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.IF_VALID  = ~bus.if_req | if_done_q;
    assign bus.MEM_VALID = ~bus.mem_req | mem_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_b;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();
    mem_port_arbiter_if #(.ADDR_W(32)) bus_b ();

    mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mem_port_arbiter #(.LATENCY(3), .ADDR_W(32)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.slave)
    );

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        bus.if_req = 0;    bus.if_addr = 0;   bus.if_flush = 0;
        bus.mem_req = 0;   bus.mem_we = 0;    bus.mem_be = 0;
        bus.mem_addr = 0;  bus.mem_wdata = 0; bus.ram_rdata = 0;
        bus_b.if_req = 0;  bus_b.if_addr = 0; bus_b.if_flush = 0;
        bus_b.mem_req = 0; bus_b.mem_we = 0;  bus_b.mem_be = 0;
        bus_b.mem_addr = 0; bus_b.mem_wdata = 0; bus_b.ram_rdata = 0;
    endtask

    task automatic do_reset;
        rst_n = 0; rst_n_b = 0;
        clear_inputs();
        cyc(); cyc();
        rst_n = 1; rst_n_b = 1;
    endtask

    task automatic test_reset;
        rst_n = 0; rst_n_b = 0;
        clear_inputs();
        #1;
        checks++;
        if ({bus.busy, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.if_rdata,
             bus.mem_rdata, bus.if_done, bus.mem_done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b en=%b we=%h addr=%h wd=%h ird=%h mrd=%h idone=%b mdone=%b, expected all 0",
                     bus.busy, bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.if_rdata,
                     bus.mem_rdata, bus.if_done, bus.mem_done);
        end
        bus.if_req = 1; bus.mem_req = 1;
        cyc();
        checks++;
        if (bus.ram_en !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: ram_en=%b busy=%b, expected 0 0", bus.ram_en, bus.busy);
        end
        $display("test_reset done");
        do_reset();
    endtask

    task automatic test_if_read;
        bus.if_req = 1; bus.if_addr = 32'h100; bus.ram_rdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.IF_VALID !== 1'b0) begin fails++; $display("FAIL if_read_valid_c0: got %b expected 0", bus.IF_VALID); end
        cyc(); // cycle 1
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h100 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL if_read_issue_c1: en=%b addr=%h busy=%b expected 1 00000100 1", bus.ram_en, bus.ram_addr, bus.busy);
        end
        cyc(); // cycle 2
        bus.ram_rdata = 32'h2402_000A;
        checks++;
        if (bus.ram_en !== 1'b0 || bus.if_done !== 1'b0) begin
            fails++;
            $display("FAIL if_read_c2: en=%b done=%b expected 0 0", bus.ram_en, bus.if_done);
        end
        cyc(); // cycle 3
        bus.ram_rdata = 32'h0BAD_0BAD;
        #1;
        checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h2402_000A || bus.IF_VALID !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL if_read_done_c3: done=%b rdata=%h valid=%b busy=%b expected 1 2402000a 1 0",
                     bus.if_done, bus.if_rdata, bus.IF_VALID, bus.busy);
        end
        cyc(); // cycle 4
        #1;
        checks++;
        if (bus.IF_VALID !== 1'b0 || bus.if_done !== 1'b0) begin
            fails++;
            $display("FAIL if_read_c4: valid=%b done=%b expected 0 0", bus.IF_VALID, bus.if_done);
        end
        $display("test_if_read done");
        do_reset();
    endtask

    task automatic test_contention;
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h300;
        cyc(); // 1
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h300) begin
            fails++; $display("FAIL contend_first_mem: en=%b addr=%h expected 1 00000300", bus.ram_en, bus.ram_addr);
        end
        cyc(); // 2
        bus.ram_rdata = 32'h1111_0000;
        cyc(); // 3
        checks++;
        if (bus.mem_done !== 1'b1 || bus.if_done !== 1'b0 || bus.mem_rdata !== 32'h1111_0000) begin
            fails++; $display("FAIL contend_mem_done_c3: mdone=%b idone=%b mrd=%h expected 1 0 11110000",
                              bus.mem_done, bus.if_done, bus.mem_rdata);
        end
        cyc(); // 4
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h100) begin
            fails++; $display("FAIL contend_if_issue_c4: en=%b addr=%h expected 1 00000100", bus.ram_en, bus.ram_addr);
        end
        cyc(); // 5
        bus.ram_rdata = 32'h2222_0000;
        cyc(); // 6
        checks++;
        if (bus.if_done !== 1'b1 || bus.mem_done !== 1'b0 || bus.if_rdata !== 32'h2222_0000) begin
            fails++; $display("FAIL contend_if_done_c6: idone=%b mdone=%b ird=%h expected 1 0 22220000",
                              bus.if_done, bus.mem_done, bus.if_rdata);
        end
        cyc(); // 7
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h300) begin
            fails++; $display("FAIL contend_mem_again_c7: en=%b addr=%h expected 1 00000300", bus.ram_en, bus.ram_addr);
        end
        cyc(); cyc(); cyc(); // 10
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h100) begin
            fails++; $display("FAIL contend_if_again_c10: en=%b addr=%h expected 1 00000100", bus.ram_en, bus.ram_addr);
        end
        $display("test_contention done");
        do_reset();
    endtask

    task automatic test_mem_write;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_be = 4'h3;
        bus.mem_addr = 32'h200; bus.mem_wdata = 32'hDEAD_BEEF;
        cyc(); // 1
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_we !== 4'h3 || bus.ram_wdata !== 32'hDEAD_BEEF || bus.ram_addr !== 32'h200) begin
            fails++; $display("FAIL write_issue_c1: en=%b we=%h wd=%h addr=%h expected 1 3 deadbeef 00000200",
                              bus.ram_en, bus.ram_we, bus.ram_wdata, bus.ram_addr);
        end
        cyc(); // 2
        bus.ram_rdata = 32'h5555_5555;
        checks++;
        if (bus.ram_en !== 1'b0 || bus.ram_we !== 4'h0) begin
            fails++; $display("FAIL write_c2: en=%b we=%h expected 0 0", bus.ram_en, bus.ram_we);
        end
        cyc(); // 3
        #1;
        checks++;
        if (bus.mem_done !== 1'b1 || bus.mem_rdata !== 32'h0 || bus.MEM_VALID !== 1'b1) begin
            fails++; $display("FAIL write_done_c3: done=%b mrd=%h valid=%b expected 1 00000000 1",
                              bus.mem_done, bus.mem_rdata, bus.MEM_VALID);
        end
        $display("test_mem_write done");
        do_reset();
    endtask

    task automatic test_flush;
        bus.if_req = 1; bus.if_addr = 32'h100;
        cyc(); cyc();
        bus.ram_rdata = 32'hAAAA_5555;
        cyc(); // done of first fetch
        bus.if_req = 0;
        cyc();
        bus.if_req = 1; bus.if_addr = 32'h104; // fetch cycle 0
        cyc(); // 1
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h104) begin
            fails++; $display("FAIL flush_issue_c1: en=%b addr=%h expected 1 00000104", bus.ram_en, bus.ram_addr);
        end
        cyc(); // 2
        bus.if_flush = 1; bus.ram_rdata = 32'h1234_5678;
        cyc(); // 3
        bus.if_flush = 0;
        checks++;
        if (bus.if_done !== 1'b0 || bus.busy !== 1'b0 || bus.if_rdata !== 32'hAAAA_5555) begin
            fails++; $display("FAIL flush_c3: done=%b busy=%b ird=%h expected 0 0 aaaa5555",
                              bus.if_done, bus.busy, bus.if_rdata);
        end
        cyc(); // 4
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== 32'h104 || bus.if_done !== 1'b0) begin
            fails++; $display("FAIL flush_refetch_c4: en=%b addr=%h done=%b expected 1 00000104 0",
                              bus.ram_en, bus.ram_addr, bus.if_done);
        end
        $display("test_flush done");
        do_reset();
    endtask

    task automatic test_back_to_back;
        int p;
        p = LAT + 3;
        bus.if_req = 1; bus.if_addr = 32'h180;
        for (int t = 1; t <= 12; t++) begin
            cyc();
            checks++;
            if (bus.ram_en !== ((t % p) == 1) || bus.if_done !== ((t % p) == LAT + 2)) begin
                fails++; $display("FAIL back_to_back_c%0d: en=%b done=%b expected %b %b",
                                  t, bus.ram_en, bus.if_done, (t % p) == 1, (t % p) == LAT + 2);
            end
        end
        $display("test_back_to_back done");
        do_reset();
    endtask

    task automatic test_async_reset;
        bus_b.mem_req = 1; bus_b.mem_we = 0; bus_b.mem_addr = 32'h40;
        cyc(); // 1
        checks++;
        if (bus_b.ram_en !== 1'b1 || bus_b.ram_addr !== 32'h40) begin
            fails++; $display("FAIL areset_issue_c1: en=%b addr=%h expected 1 00000040", bus_b.ram_en, bus_b.ram_addr);
        end
        cyc(); // 2
        checks++;
        if (bus_b.busy !== 1'b1) begin fails++; $display("FAIL areset_busy_c2: got %b expected 1", bus_b.busy); end
        #2 rst_n_b = 0;
        #1;
        checks++;
        if ({bus_b.busy, bus_b.ram_en, bus_b.ram_we, bus_b.ram_addr, bus_b.ram_wdata, bus_b.if_rdata,
             bus_b.mem_rdata, bus_b.if_done, bus_b.mem_done} !== '0) begin
            fails++; $display("FAIL areset_immediate: busy=%b en=%b addr=%h mdone=%b expected all 0",
                              bus_b.busy, bus_b.ram_en, bus_b.ram_addr, bus_b.mem_done);
        end
        @(negedge clk);
        rst_n_b = 1; // cycle 0 after release, mem_req still held
        for (int t = 1; t <= 5; t++) begin
            cyc();
            checks++;
            if (bus_b.ram_en !== (t == 1) || bus_b.mem_done !== (t == 5)) begin
                fails++; $display("FAIL areset_rearb_c%0d: en=%b mdone=%b expected %b %b",
                                  t, bus_b.ram_en, bus_b.mem_done, t == 1, t == 5);
            end
        end
        $display("test_async_reset done");
        do_reset();
    endtask

    // Transaction-level model: each grant is a timestamped record; RAM strobe,
    // capture and done times follow from the grant cycle and LAT.
    task automatic test_random;
        bit act, g_if, g_we, kill, last_if, e_if_done, e_mem_done, e_en, ie, me;
        int g;
        logic [31:0] g_addr, e_if_rd, e_mem_rd;
        logic [3:0] g_be;
        act = 0; kill = 0; last_if = 1; g = 0; g_if = 0; g_we = 0; g_be = 0; g_addr = 0;
        e_if_rd = 0; e_mem_rd = 0;
        for (int t = 0; t < 600; t++) begin
            e_if_done = 0; e_mem_done = 0;
            if (act && t == g + LAT + 2) begin
                if (g_if) e_if_done = !kill; else e_mem_done = 1;
                act = 0;
            end
            e_en = act && (t == g + 1);
            checks++;
            if (bus.ram_en !== e_en || bus.busy !== act || bus.if_done !== e_if_done || bus.mem_done !== e_mem_done) begin
                fails++; $display("FAIL random_ctrl_t%0d: en=%b busy=%b idone=%b mdone=%b expected %b %b %b %b",
                                  t, bus.ram_en, bus.busy, bus.if_done, bus.mem_done, e_en, act, e_if_done, e_mem_done);
            end
            checks++;
            if (bus.if_rdata !== e_if_rd || bus.mem_rdata !== e_mem_rd) begin
                fails++; $display("FAIL random_rdata_t%0d: ird=%h mrd=%h expected %h %h",
                                  t, bus.if_rdata, bus.mem_rdata, e_if_rd, e_mem_rd);
            end
            if (e_en) begin
                checks++;
                if (bus.ram_addr !== g_addr || bus.ram_we !== (g_we ? g_be : 4'h0)) begin
                    fails++; $display("FAIL random_cmd_t%0d: addr=%h we=%h expected %h %h",
                                      t, bus.ram_addr, bus.ram_we, g_addr, g_we ? g_be : 4'h0);
                end
            end
            // requesters: hold until done, then drop or start a new request
            if (!bus.if_req) begin
                if ($urandom_range(2) == 0) begin bus.if_req = 1; bus.if_addr = $urandom; end
            end else if (e_if_done) begin
                if ($urandom_range(1) == 1) bus.if_req = 0; else bus.if_addr = $urandom;
            end
            if (!bus.mem_req) begin
                if ($urandom_range(2) == 0) begin
                    bus.mem_req = 1; bus.mem_we = 1'($urandom_range(1)); bus.mem_be = 4'($urandom);
                    bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
                end
            end else if (e_mem_done) begin
                if ($urandom_range(1) == 1) bus.mem_req = 0;
                else begin
                    bus.mem_we = 1'($urandom_range(1)); bus.mem_be = 4'($urandom);
                    bus.mem_addr = $urandom; bus.mem_wdata = $urandom;
                end
            end
            bus.if_flush = ($urandom_range(7) == 0);
            bus.ram_rdata = $urandom;
            #1;
            checks++;
            if (bus.IF_VALID !== (!bus.if_req || e_if_done) || bus.MEM_VALID !== (!bus.mem_req || e_mem_done)) begin
                fails++; $display("FAIL random_valid_t%0d: if_valid=%b mem_valid=%b expected %b %b",
                                  t, bus.IF_VALID, bus.MEM_VALID, !bus.if_req || e_if_done, !bus.mem_req || e_mem_done);
            end
            if (act && g_if && bus.if_flush) kill = 1;
            if (act && t == g + 1 + LAT) begin
                if (g_if) begin
                    if (!kill) e_if_rd = bus.ram_rdata;
                end else if (!g_we) begin
                    e_mem_rd = bus.ram_rdata;
                end
            end
            if (!act) begin
                ie = bus.if_req && !bus.if_flush && !e_if_done;
                me = bus.mem_req && !e_mem_done;
                if (ie || me) begin
                    g_if = ie && (!me || !last_if);
                    last_if = g_if;
                    act = 1; g = t; kill = 0;
                    g_addr = g_if ? bus.if_addr : bus.mem_addr;
                    g_we = !g_if && bus.mem_we;
                    g_be = bus.mem_be;
                end
            end
            cyc();
        end
        $display("test_random done");
        do_reset();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_contention();
        test_mem_write();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
